// File: rtl/rv_ctrl_pkg.sv
// rtl/rv_ctrl_pkg.sv - shared opcodes, state codes and select encodings for the RV32I control path
package rv_ctrl_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef logic [2:0] state_t;
    localparam state_t S_FETCH  = 3'd0;
    localparam state_t S_DECODE = 3'd1;
    localparam state_t S_EXEC   = 3'd2;
    localparam state_t S_MEM    = 3'd3;
    localparam state_t S_WB     = 3'd4;
    localparam state_t S_TRAP   = 3'd5;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_PC4  = 2'b10
    } wb_sel_e;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'b00,
        PC_IMM   = 2'b01,
        PC_JALR  = 2'b10
    } pc_sel_e;

    typedef enum logic [3:0] {
        CL_OP, CL_OPIMM, CL_LOAD, CL_STORE, CL_BRANCH, CL_JAL,
        CL_JALR, CL_LUI, CL_AUIPC, CL_SYSTEM, CL_ILLEGAL
    } op_class_e;

endpackage

// File: rtl/op_classify.sv
// rtl/op_classify.sv - combinational opcode to instruction class decode
module op_classify
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output op_class_e  op_class
);

    always_comb begin
        case (opcode)
            OPC_OP:     op_class = CL_OP;
            OPC_OPIMM:  op_class = CL_OPIMM;
            OPC_LOAD:   op_class = CL_LOAD;
            OPC_STORE:  op_class = CL_STORE;
            OPC_BRANCH: op_class = CL_BRANCH;
            OPC_JAL:    op_class = CL_JAL;
            OPC_JALR:   op_class = CL_JALR;
            OPC_LUI:    op_class = CL_LUI;
            OPC_AUIPC:  op_class = CL_AUIPC;
            OPC_SYSTEM: op_class = CL_SYSTEM;
            default:    op_class = CL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// rtl/mc_ctrl.sv - multi-cycle fetch/decode/exec/mem/wb sequencer with retired-instruction counter
module mc_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    output logic             imem_req,
    input  logic             imem_ack,
    output logic             ir_we,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic             alu_src_imm,
    output logic             alu_src_pc,
    output logic             rf_we,
    output logic [1:0]       wb_sel,
    output logic             pc_we,
    output logic [1:0]       pc_sel,
    output logic             halted,
    output logic [CNT_W-1:0] instret
);

    state_t    state;
    state_t    state_next;
    op_class_e op_class;
    logic      retire;

    op_classify u_op_classify (
        .opcode   (opcode),
        .op_class (op_class)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_FETCH;
            instret <= '0;
        end else begin
            state <= state_next;
            if (retire) begin
                instret <= instret + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_next  = state;
        imem_req    = 1'b0;
        ir_we       = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        alu_src_imm = 1'b0;
        alu_src_pc  = 1'b0;
        rf_we       = 1'b0;
        wb_sel      = WB_ALU;
        pc_we       = 1'b0;
        pc_sel      = PC_PLUS4;
        halted      = 1'b0;
        retire      = 1'b0;
        case (state)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we      = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (op_class == CL_ILLEGAL || op_class == CL_SYSTEM) begin
                    state_next = S_TRAP;
                end else begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                alu_src_imm = !(op_class == CL_OP || op_class == CL_BRANCH);
                alu_src_pc  = (op_class == CL_AUIPC || op_class == CL_JAL);
                if (op_class == CL_BRANCH) begin
                    pc_we      = 1'b1;
                    pc_sel     = branch_taken ? PC_IMM : PC_PLUS4;
                    retire     = 1'b1;
                    state_next = S_FETCH;
                end else if (op_class == CL_LOAD || op_class == CL_STORE) begin
                    state_next = S_MEM;
                end else begin
                    state_next = S_WB;
                end
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (op_class == CL_STORE);
                // Store completes here, so its PC update rides on the ack itself.
                if (dmem_ack) begin
                    if (op_class == CL_STORE) begin
                        pc_we      = 1'b1;
                        retire     = 1'b1;
                        state_next = S_FETCH;
                    end else begin
                        state_next = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_we      = 1'b1;
                pc_we      = 1'b1;
                retire     = 1'b1;
                state_next = S_FETCH;
                if (op_class == CL_LOAD) begin
                    wb_sel = WB_LOAD;
                end else if (op_class == CL_JAL || op_class == CL_JALR) begin
                    wb_sel = WB_PC4;
                end
                if (op_class == CL_JAL) begin
                    pc_sel = PC_IMM;
                end else if (op_class == CL_JALR) begin
                    pc_sel = PC_JALR;
                end
            end
            S_TRAP: begin
                halted = 1'b1;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
        // Reset silences every output in the cycle it is applied, whatever the state.
        if (rst) begin
            imem_req    = 1'b0;
            ir_we       = 1'b0;
            dmem_req    = 1'b0;
            dmem_we     = 1'b0;
            alu_src_imm = 1'b0;
            alu_src_pc  = 1'b0;
            rf_we       = 1'b0;
            wb_sel      = WB_ALU;
            pc_we       = 1'b0;
            pc_sel      = PC_PLUS4;
            halted      = 1'b0;
            retire      = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// tb/tb_mc_ctrl.sv - directed self-checking bench for mc_ctrl
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode;
    logic        branch_taken;
    logic        imem_req;
    logic        imem_ack;
    logic        ir_we;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic        alu_src_imm;
    logic        alu_src_pc;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        halted;
    logic [31:0] instret;

    int n_tests = 0;
    int n_fail  = 0;

    mc_ctrl #(.CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .imem_req     (imem_req),
        .imem_ack     (imem_ack),
        .ir_we        (ir_we),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_ack     (dmem_ack),
        .alu_src_imm  (alu_src_imm),
        .alu_src_pc   (alu_src_pc),
        .rf_we        (rf_we),
        .wb_sel       (wb_sel),
        .pc_we        (pc_we),
        .pc_sel       (pc_sel),
        .halted       (halted),
        .instret      (instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [6:0] opc);
        opcode   = opc;
        imem_ack = 1'b1;
        #1;
        chk("fetch_imem_req", 32'(imem_req), 32'd1);
        chk("fetch_ir_we", 32'(ir_we), 32'd1);
        tick();
        imem_ack = 1'b0;
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        opcode       = 7'b0;
        branch_taken = 1'b0;
        imem_ack     = 1'b0;
        dmem_ack     = 1'b0;
        tick();
        tick();
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_instret", instret, 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_pc_we", 32'(pc_we), 32'd0);

        rst = 1'b0;
        #1;
        chk("post_rst_imem_req", 32'(imem_req), 32'd1);
        chk("post_rst_ir_we_no_ack", 32'(ir_we), 32'd0);

        // ADD, zero-wait: FETCH, DECODE, EXEC, WB
        fetch(7'b0110011);
        chk("add_dec_imem_req", 32'(imem_req), 32'd0);
        tick();
        chk("add_exec_src_imm", 32'(alu_src_imm), 32'd0);
        chk("add_exec_rf_we", 32'(rf_we), 32'd0);
        tick();
        chk("add_wb_rf_we", 32'(rf_we), 32'd1);
        chk("add_wb_sel", 32'(wb_sel), 32'd0);
        chk("add_wb_pc_we", 32'(pc_we), 32'd1);
        chk("add_wb_pc_sel", 32'(pc_sel), 32'd0);
        chk("add_wb_instret", instret, 32'd0);
        tick();
        chk("add_instret", instret, 32'd1);
        chk("add_next_fetch", 32'(imem_req), 32'd1);

        // LW with dmem_ack delayed three cycles
        fetch(7'b0000011);
        tick();
        chk("lw_exec_src_imm", 32'(alu_src_imm), 32'd1);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("lw_mem_wait_req", 32'(dmem_req), 32'd1);
            chk("lw_mem_wait_we", 32'(dmem_we), 32'd0);
            tick();
        end
        dmem_ack = 1'b1;
        #1;
        chk("lw_mem_ack_req", 32'(dmem_req), 32'd1);
        chk("lw_mem_ack_rf_we", 32'(rf_we), 32'd0);
        tick();
        dmem_ack = 1'b0;
        #1;
        chk("lw_wb_rf_we", 32'(rf_we), 32'd1);
        chk("lw_wb_sel", 32'(wb_sel), 32'd1);
        chk("lw_wb_dmem_req", 32'(dmem_req), 32'd0);
        tick();
        chk("lw_instret", instret, 32'd2);
        chk("lw_next_fetch", 32'(imem_req), 32'd1);

        // BEQ taken then not taken, three cycles each
        branch_taken = 1'b1;
        fetch(7'b1100011);
        chk("beq_t_dec_rf_we", 32'(rf_we), 32'd0);
        tick();
        chk("beq_t_pc_we", 32'(pc_we), 32'd1);
        chk("beq_t_pc_sel", 32'(pc_sel), 32'd1);
        chk("beq_t_rf_we", 32'(rf_we), 32'd0);
        chk("beq_t_src_imm", 32'(alu_src_imm), 32'd0);
        tick();
        chk("beq_t_instret", instret, 32'd3);
        chk("beq_t_next_fetch", 32'(imem_req), 32'd1);
        branch_taken = 1'b0;
        fetch(7'b1100011);
        tick();
        chk("beq_n_pc_we", 32'(pc_we), 32'd1);
        chk("beq_n_pc_sel", 32'(pc_sel), 32'd0);
        chk("beq_n_rf_we", 32'(rf_we), 32'd0);
        tick();
        chk("beq_n_instret", instret, 32'd4);

        // JALR
        fetch(7'b1100111);
        tick();
        chk("jalr_src_imm", 32'(alu_src_imm), 32'd1);
        chk("jalr_src_pc", 32'(alu_src_pc), 32'd0);
        tick();
        chk("jalr_rf_we", 32'(rf_we), 32'd1);
        chk("jalr_wb_sel", 32'(wb_sel), 32'd2);
        chk("jalr_pc_sel", 32'(pc_sel), 32'd2);
        chk("jalr_pc_we", 32'(pc_we), 32'd1);
        tick();
        chk("jalr_instret", instret, 32'd5);

        // SW: pc_we follows dmem_ack combinationally
        fetch(7'b0100011);
        tick();
        chk("sw_src_imm", 32'(alu_src_imm), 32'd1);
        tick();
        chk("sw_mem_req", 32'(dmem_req), 32'd1);
        chk("sw_mem_we", 32'(dmem_we), 32'd1);
        chk("sw_pc_we_no_ack", 32'(pc_we), 32'd0);
        dmem_ack = 1'b1;
        #1;
        chk("sw_pc_we_ack", 32'(pc_we), 32'd1);
        chk("sw_pc_sel", 32'(pc_sel), 32'd0);
        chk("sw_rf_we", 32'(rf_we), 32'd0);
        tick();
        dmem_ack = 1'b0;
        #1;
        chk("sw_instret", instret, 32'd6);
        chk("sw_next_fetch", 32'(imem_req), 32'd1);

        // Illegal opcode 0101111 traps after DECODE
        fetch(7'b0101111);
        chk("ill_dec_halted", 32'(halted), 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("ill_halted", 32'(halted), 32'd1);
            chk("ill_imem_req", 32'(imem_req), 32'd0);
            chk("ill_instret", instret, 32'd6);
            tick();
        end
        imem_ack = 1'b1;
        #1;
        chk("ill_stray_ack_ir_we", 32'(ir_we), 32'd0);
        imem_ack = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("trap_recover_halted", 32'(halted), 32'd0);
        chk("trap_recover_fetch", 32'(imem_req), 32'd1);

        // Reset mid-MEM during a load
        fetch(7'b0000011);
        tick();
        tick();
        chk("rstmem_req", 32'(dmem_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstmem_req_gated", 32'(dmem_req), 32'd0);
        tick();
        chk("rstmem_next_req", 32'(dmem_req), 32'd0);
        chk("rstmem_instret", instret, 32'd0);
        chk("rstmem_imem_req_held", 32'(imem_req), 32'd0);
        rst = 1'b0;
        #1;
        chk("rstmem_imem_req", 32'(imem_req), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
